// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocation of up to ALLOC_W micro-ops per cycle, out-of-order completion,
// and in-order retirement of up to COMMIT_W entries per cycle, with mispredict and external flush recovery.
module rob_multi_commit #(
    parameter int ENTRIES  = 64,
    parameter int ALLOC_W  = 4,
    parameter int WB_W     = 4,
    parameter int COMMIT_W = 2,
    parameter int PHYS_W   = 7,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ALLOC_W-1:0]           alloc_valid_i,
    input  logic [ALLOC_W*PHYS_W-1:0]    dest_phys_i,
    input  logic [ALLOC_W*PHYS_W-1:0]    old_dest_phys_i,
    input  logic [ALLOC_W-1:0]           is_store_i,
    input  logic [ALLOC_W-1:0]           is_branch_i,
    output logic                         alloc_ready_o,
    output logic [ALLOC_W*IDX_W-1:0]     alloc_idx_o,
    input  logic [WB_W-1:0]              wb_valid_i,
    input  logic [WB_W*IDX_W-1:0]        wb_idx_i,
    input  logic [WB_W-1:0]              wb_misp_i,
    input  logic                         flush_i,
    input  logic                         commit_ready_i,
    output logic [COMMIT_W-1:0]          commit_valid_o,
    output logic [COMMIT_W*IDX_W-1:0]    commit_idx_o,
    output logic [COMMIT_W*PHYS_W-1:0]   commit_rd_phys_o,
    output logic [COMMIT_W*PHYS_W-1:0]   commit_old_phys_o,
    output logic [COMMIT_W-1:0]          commit_is_store_o,
    output logic [COMMIT_W-1:0]          commit_branch_misp_o,
    output logic [IDX_W:0]               count_o,
    output logic                         empty_o
);

    localparam logic [IDX_W:0] FULL_TH = (IDX_W+1)'(ENTRIES - ALLOC_W);

    logic [ENTRIES-1:0] valid_q, done_q, misp_q, store_q, branch_q;
    logic [PHYS_W-1:0]  rd_q  [ENTRIES];
    logic [PHYS_W-1:0]  old_q [ENTRIES];
    logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]     count_q, count_d;

    logic [IDX_W:0]     n_alloc, n_alloc_eff, n_ret, n_ret_eff, alloc_off;
    logic [IDX_W-1:0]   cidx;
    logic               blocked, ret_misp, do_recover;
    logic [ENTRIES-1:0] wb_hit, wb_misp;

    assign alloc_ready_o = (count_q <= FULL_TH);
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);

    // Valid lanes are packed onto consecutive slots starting at tail.
    always_comb begin
        alloc_off   = '0;
        alloc_idx_o = '0;
        for (int j = 0; j < ALLOC_W; j++) begin
            alloc_idx_o[j*IDX_W +: IDX_W] = tail_q + alloc_off[IDX_W-1:0];
            if (alloc_valid_i[j]) alloc_off = alloc_off + 1'b1;
        end
        n_alloc = alloc_off;
    end

    always_comb begin
        blocked              = 1'b0;
        ret_misp             = 1'b0;
        n_ret                = '0;
        cidx                 = '0;
        commit_valid_o       = '0;
        commit_idx_o         = '0;
        commit_rd_phys_o     = '0;
        commit_old_phys_o    = '0;
        commit_is_store_o    = '0;
        commit_branch_misp_o = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            cidx = head_q + IDX_W'(k);
            commit_idx_o[k*IDX_W +: IDX_W]       = cidx;
            commit_rd_phys_o[k*PHYS_W +: PHYS_W]  = rd_q[cidx];
            commit_old_phys_o[k*PHYS_W +: PHYS_W] = old_q[cidx];
            if (!blocked && valid_q[cidx] && done_q[cidx]) begin
                commit_valid_o[k] = 1'b1;
                n_ret             = n_ret + 1'b1;
                if (misp_q[cidx]) ret_misp = 1'b1;
            end else begin
                blocked = 1'b1;
            end
            // A mispredicted entry closes the retire group.
            if (misp_q[cidx]) blocked = 1'b1;
            commit_is_store_o[k]    = commit_valid_o[k] & store_q[cidx];
            commit_branch_misp_o[k] = commit_valid_o[k] & branch_q[cidx] & misp_q[cidx];
        end
    end

    always_comb begin
        wb_hit  = '0;
        wb_misp = '0;
        for (int p = 0; p < WB_W; p++) begin
            if (wb_valid_i[p] && valid_q[wb_idx_i[p*IDX_W +: IDX_W]]) begin
                wb_hit[wb_idx_i[p*IDX_W +: IDX_W]]  = 1'b1;
                wb_misp[wb_idx_i[p*IDX_W +: IDX_W]] = wb_misp[wb_idx_i[p*IDX_W +: IDX_W]] | wb_misp_i[p];
            end
        end
    end

    assign do_recover  = commit_ready_i & ret_misp;
    assign n_alloc_eff = alloc_ready_o ? n_alloc : '0;
    assign n_ret_eff   = commit_ready_i ? n_ret : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            tail_d  = head_q;
            count_d = '0;
        end else begin
            head_d = head_q + n_ret_eff[IDX_W-1:0];
            if (do_recover) begin
                tail_d  = head_d;
                count_d = '0;
            end else begin
                tail_d  = tail_q + n_alloc_eff[IDX_W-1:0];
                count_d = count_q + n_alloc_eff - n_ret_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            done_q   <= '0;
            misp_q   <= '0;
            store_q  <= '0;
            branch_q <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                rd_q[e]  <= '0;
                old_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush_i) begin
                valid_q <= '0;
            end else begin
                for (int e = 0; e < ENTRIES; e++) begin
                    if (wb_hit[e]) begin
                        done_q[e] <= 1'b1;
                        misp_q[e] <= wb_misp[e];
                    end
                end
                if (do_recover) begin
                    valid_q <= '0;
                end else begin
                    for (int k = 0; k < COMMIT_W; k++) begin
                        if (commit_ready_i && commit_valid_o[k]) valid_q[head_q + IDX_W'(k)] <= 1'b0;
                    end
                    if (alloc_ready_o) begin
                        for (int j = 0; j < ALLOC_W; j++) begin
                            if (alloc_valid_i[j]) begin
                                valid_q[alloc_idx_o[j*IDX_W +: IDX_W]]  <= 1'b1;
                                done_q[alloc_idx_o[j*IDX_W +: IDX_W]]   <= 1'b0;
                                misp_q[alloc_idx_o[j*IDX_W +: IDX_W]]   <= 1'b0;
                                store_q[alloc_idx_o[j*IDX_W +: IDX_W]]  <= is_store_i[j];
                                branch_q[alloc_idx_o[j*IDX_W +: IDX_W]] <= is_branch_i[j];
                                rd_q[alloc_idx_o[j*IDX_W +: IDX_W]]     <= dest_phys_i[j*PHYS_W +: PHYS_W];
                                old_q[alloc_idx_o[j*IDX_W +: IDX_W]]    <= old_dest_phys_i[j*PHYS_W +: PHYS_W];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
